// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the VGA frame-buffer write scheduler.
// Optional feature macro used by the top: VGA_FB_SCHED_FAIR_EN.
package vga_fb_pkg;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 19;
  localparam logic [ADDR_W-1:0] RAM_SIZE_DEF = 19'h4B000;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] fbAddr_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_BAR, ST_DONE} schedState_t;

  typedef struct packed {
    pix_t       fg;
    pix_t       bg;
    logic [9:0] fgStart;
  } barOp_t;

  // First row painted FG; heights past the screen saturate to a full bar.
  function automatic logic [9:0] barFgStart(input logic [8:0] h, input int vRes);
    logic [9:0] hExt;
    hExt = {1'b0, h};
    if (hExt >= 10'(vRes)) return 10'd0;
    else                   return 10'(vRes) - hExt;
  endfunction
endpackage

// File: rtl/vga_fb_write_sched_if.sv
// Host pixel-write bus and frame-buffer write port seen by the scheduler.
interface vga_fb_write_sched_if;
  import vga_fb_pkg::*;
  logic    iHOST_WR;
  fbAddr_t iHOST_ADDR;
  pix_t    iHOST_DATA;
  logic    oHOST_WAIT;
  logic    oFB_WREN;
  fbAddr_t oFB_ADDR;
  pix_t    oFB_DATA;

  modport slave  (input  iHOST_WR, iHOST_ADDR, iHOST_DATA,
                  output oHOST_WAIT, oFB_WREN, oFB_ADDR, oFB_DATA);
  modport master (output iHOST_WR, iHOST_ADDR, iHOST_DATA,
                  input  oHOST_WAIT, oFB_WREN, oFB_ADDR, oFB_DATA);
endinterface

// File: rtl/vga_fb_addr_gen.sv
// Loadable address/row counter for the fill engines; holds while not advanced.
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int STRIDE = H_RES_DEF
) (
  input  logic    iCLK,
  input  logic    iRST_N,
  input  logic    load,
  input  fbAddr_t loadAddr,
  input  fbAddr_t loadTerm,
  input  logic    loadRowStep,
  input  logic    adv,
  output fbAddr_t addr,
  output fbAddr_t cnt,
  output logic    last
);
  localparam fbAddr_t ROW_STEP = fbAddr_t'(STRIDE);

  fbAddr_t termR;
  logic    rowStepR;

  assign last = (cnt == termR);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      addr     <= '0;
      cnt      <= '0;
      termR    <= '0;
      rowStepR <= 1'b0;
    end else if (load) begin
      addr     <= loadAddr;
      cnt      <= '0;
      termR    <= loadTerm;
      rowStepR <= loadRowStep;
    end else if (adv && !last) begin
      addr <= addr + (rowStepR ? ROW_STEP : fbAddr_t'(1));
      cnt  <= cnt + fbAddr_t'(1);
    end
  end
endmodule

// File: rtl/vga_fb_write_sched.sv
// Frame-buffer write-port scheduler: host pixel writes vs clear / column-bar engines.
// Define VGA_FB_SCHED_FAIR_EN for alternating host/engine grants; default is host priority.
module vga_fb_write_sched
  import vga_fb_pkg::*;
#(
  parameter fbAddr_t RAM_SIZE = RAM_SIZE_DEF,
  parameter int      H_RES    = H_RES_DEF,
  parameter int      V_RES    = V_RES_DEF
) (
  input  logic                  avs_s1_clk_iCLK,
  input  logic                  avs_s1_reset_n_iRST_N,
  vga_fb_write_sched_if.slave   bus,
  input  logic                  iCLR_REQ,
  input  pix_t                  iCLR_COLOR,
  input  logic                  iBAR_REQ,
  input  logic [9:0]            iBAR_X,
  input  logic [8:0]            iBAR_H,
  input  pix_t                  iBAR_FG,
  input  pix_t                  iBAR_BG,
  output logic                  oACK,
  output logic                  oBUSY,
  output logic                  oDONE
);
  localparam logic [9:0] H_RES_X = 10'(H_RES);

  schedState_t state, nxt;
  logic        accept, acceptClr;
  logic        hostValid, engWant, engGrant, hostGrant, hostWait;
  pix_t        colorR, engData;
  barOp_t      barR;
  fbAddr_t     engAddr, engCnt;
  logic        engLast;

  // Register-space addresses bypass arbitration entirely.
  assign hostValid = bus.iHOST_WR && (bus.iHOST_ADDR < RAM_SIZE);
  assign engWant   = (state == ST_CLEAR) || (state == ST_BAR);
  assign oBUSY     = (state != ST_IDLE);

`ifdef VGA_FB_SCHED_FAIR_EN
  logic lastEngR;

  always_comb begin
    engGrant  = engWant && (!hostValid || !lastEngR);
    hostGrant = hostValid && !engGrant;
    hostWait  = hostValid && engGrant;
  end

  always_ff @(posedge avs_s1_clk_iCLK or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N)     lastEngR <= 1'b0;
    else if (engGrant || hostGrant) lastEngR <= engGrant;
  end
`else
  always_comb begin
    engGrant  = engWant && !hostValid;
    hostGrant = hostValid;
    hostWait  = 1'b0;
  end
`endif

  assign bus.oHOST_WAIT = hostWait;

  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    acceptClr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iCLR_REQ) begin
          accept    = 1'b1;
          acceptClr = 1'b1;
          nxt       = ST_CLEAR;
        end else if (iBAR_REQ) begin
          accept = 1'b1;
          nxt    = (iBAR_X >= H_RES_X) ? ST_DONE : ST_BAR;
        end
      end
      ST_CLEAR, ST_BAR: if (engGrant && engLast) nxt = ST_DONE;
      ST_DONE:          nxt = ST_IDLE;
      default:          nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge avs_s1_clk_iCLK or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      state  <= ST_IDLE;
      oACK   <= 1'b0;
      oDONE  <= 1'b0;
      colorR <= '0;
      barR   <= '0;
    end else begin
      state <= nxt;
      oACK  <= accept;
      oDONE <= (state == ST_DONE);
      if (accept) begin
        colorR       <= iCLR_COLOR;
        barR.fg      <= iBAR_FG;
        barR.bg      <= iBAR_BG;
        barR.fgStart <= barFgStart(iBAR_H, V_RES);
      end
    end
  end

  vga_fb_addr_gen #(.STRIDE(H_RES)) u_addr (
    .iCLK        (avs_s1_clk_iCLK),
    .iRST_N      (avs_s1_reset_n_iRST_N),
    .load        (accept),
    .loadAddr    (acceptClr ? fbAddr_t'(0) : fbAddr_t'(iBAR_X)),
    .loadTerm    (acceptClr ? (RAM_SIZE - fbAddr_t'(1)) : fbAddr_t'(V_RES - 1)),
    .loadRowStep (!acceptClr),
    .adv         (engGrant),
    .addr        (engAddr),
    .cnt         (engCnt),
    .last        (engLast)
  );

  // In BAR the counter is the row index, so FG covers the bottom rows.
  assign engData = (state == ST_BAR)
                   ? ((engCnt >= fbAddr_t'(barR.fgStart)) ? barR.fg : barR.bg)
                   : colorR;

  always_ff @(posedge avs_s1_clk_iCLK or negedge avs_s1_reset_n_iRST_N) begin
    if (!avs_s1_reset_n_iRST_N) begin
      bus.oFB_WREN <= 1'b0;
      bus.oFB_ADDR <= '0;
      bus.oFB_DATA <= '0;
    end else begin
      bus.oFB_WREN <= hostGrant || engGrant;
      if (hostGrant) begin
        bus.oFB_ADDR <= bus.iHOST_ADDR;
        bus.oFB_DATA <= bus.iHOST_DATA;
      end else if (engGrant) begin
        bus.oFB_ADDR <= engAddr;
        bus.oFB_DATA <= engData;
      end
    end
  end
endmodule

// File: tb/tb_vga_fb_write_sched.sv
// Directed bench for vga_fb_write_sched; RAM_SIZE is shrunk to keep the clear short.
// Expectations follow VGA_FB_SCHED_FAIR_EN when the build defines it.
module tb_vga_fb_write_sched;
  localparam logic [18:0] RAM = 19'h1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iCLR_REQ = 1'b0, iBAR_REQ = 1'b0;
  logic [7:0] iCLR_COLOR = '0, iBAR_FG = '0, iBAR_BG = '0;
  logic [9:0] iBAR_X = '0;
  logic [8:0] iBAR_H = '0;
  logic       oACK, oBUSY, oDONE;

  vga_fb_write_sched_if bus();

  vga_fb_write_sched #(.RAM_SIZE(RAM), .H_RES(640), .V_RES(480)) dut (
    .avs_s1_clk_iCLK       (clk),
    .avs_s1_reset_n_iRST_N (rst_n),
    .bus                   (bus),
    .iCLR_REQ              (iCLR_REQ),
    .iCLR_COLOR            (iCLR_COLOR),
    .iBAR_REQ              (iBAR_REQ),
    .iBAR_X                (iBAR_X),
    .iBAR_H                (iBAR_H),
    .iBAR_FG               (iBAR_FG),
    .iBAR_BG               (iBAR_BG),
    .oACK                  (oACK),
    .oBUSY                 (oBUSY),
    .oDONE                 (oDONE)
  );

  always #5 clk = ~clk;

  int nCmp = 0, nBad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state: expected engine stream and observed event counts
  int          monMode;   // 0 clear, 1 bar
  int          monX, monH;
  logic [7:0]  monColor, monFg, monBg;
  logic [18:0] hostA;
  int engWr, engBad, hostWr, ackCnt, doneCnt;
  int ackCyc, doneCyc, firstEngCyc, lastEngCyc;

  function automatic logic [18:0] mAddr(int i);
    if (monMode == 0) return 19'(i);
    else              return 19'(monX + 640 * i);
  endfunction

  function automatic logic [7:0] mData(int i);
    int hs;
    hs = (monH > 480) ? 480 : monH;
    if (monMode == 0)      return monColor;
    else if (i >= 480 - hs) return monFg;
    else                    return monBg;
  endfunction

  always @(negedge clk) begin
    if (bus.oFB_WREN) begin
      if (bus.oFB_DATA == 8'hA5 && bus.oFB_ADDR == hostA) hostWr <= hostWr + 1;
      else begin
        if (bus.oFB_ADDR != mAddr(engWr) || bus.oFB_DATA != mData(engWr)) engBad <= engBad + 1;
        if (engWr == 0) firstEngCyc <= cyc;
        lastEngCyc <= cyc;
        engWr      <= engWr + 1;
      end
    end
    if (oACK)  begin ackCnt  <= ackCnt + 1;  ackCyc  <= cyc; end
    if (oDONE) begin doneCnt <= doneCnt + 1; doneCyc <= cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic arm(input int mode, input int x, input int h, input logic [7:0] c,
                     input logic [7:0] fg, input logic [7:0] bg, input logic [18:0] ha);
    monMode = mode; monX = x; monH = h; monColor = c; monFg = fg; monBg = bg; hostA = ha;
    engWr = 0; engBad = 0; hostWr = 0; ackCnt = 0; doneCnt = 0;
    ackCyc = 0; doneCyc = 0; firstEngCyc = 0; lastEngCyc = 0;
  endtask

  task automatic reqClr(input logic [7:0] c);
    @(negedge clk);
    iCLR_REQ = 1'b1; iCLR_COLOR = c;
    @(negedge clk);
    iCLR_REQ = 1'b0;
  endtask

  task automatic reqBar(input int x, input int h, input logic [7:0] fg, input logic [7:0] bg);
    @(negedge clk);
    iBAR_REQ = 1'b1; iBAR_X = 10'(x); iBAR_H = 9'(h); iBAR_FG = fg; iBAR_BG = bg;
    @(negedge clk);
    iBAR_REQ = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxc);
    int n;
    n = 0;
    while (!oDONE && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) chk({tag, "_tmo"}, 32'd1, 32'd0);
    else           chk({tag, "_busy_at_done"}, 32'(oBUSY), 32'd0);
    @(negedge clk);
  endtask

  task automatic barCase(input string tag, input int x, input int h,
                         input logic [7:0] fg, input logic [7:0] bg);
    arm(1, x, h, 8'h00, fg, bg, 19'h7FFFF);
    reqBar(x, h, fg, bg);
    waitDone(tag, 700);
    chk({tag, "_wr"}, 32'(engWr), 32'd480);
    chk({tag, "_bad"}, 32'(engBad), 32'd0);
    chk({tag, "_span"}, 32'(doneCyc - ackCyc), 32'd481);
  endtask

  initial begin
    int n, waits, reps;
    logic w, pw;
    bus.iHOST_WR = 1'b0; bus.iHOST_ADDR = '0; bus.iHOST_DATA = '0;
    arm(0, 0, 0, 8'h00, 8'h00, 8'h00, 19'h7FFFF);

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_wren", 32'(bus.oFB_WREN), 0);
    chk("rst_addr", 32'(bus.oFB_ADDR), 0);
    chk("rst_data", 32'(bus.oFB_DATA), 0);
    chk("rst_ctl",  {28'd0, oACK, oBUSY, oDONE, bus.oHOST_WAIT}, 0);
    rst_n = 1'b1;

    // reset in the middle of a clear
    arm(0, 0, 0, 8'h5A, 8'h00, 8'h00, 19'h7FFFF);
    reqClr(8'h5A);
    n = 0;
    while (!(bus.oFB_WREN && bus.oFB_ADDR == 19'h100) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("midrst_tmo", 32'd1, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {bus.oFB_WREN, bus.oFB_ADDR, bus.oFB_DATA, oACK, oBUSY, oDONE}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    arm(0, 0, 0, 8'h5A, 8'h00, 8'h00, 19'h7FFFF);
    repeat (20) @(negedge clk);
    chk("midrst_idle_wr", 32'(engWr + hostWr), 0);
    chk("midrst_idle_busy", 32'(oBUSY), 0);

    // unstalled clear
    arm(0, 0, 0, 8'h3C, 8'h00, 8'h00, 19'h7FFFF);
    reqClr(8'h3C);
    chk("clr_ack", 32'(oACK), 1);
    chk("clr_busy", 32'(oBUSY), 1);
    waitDone("clr", 32'(RAM) + 50);
    chk("clr_wr", 32'(engWr), 32'(RAM));
    chk("clr_bad", 32'(engBad), 0);
    chk("clr_done_cnt", 32'(doneCnt), 1);
    chk("clr_first", 32'(firstEngCyc - ackCyc), 1);
    chk("clr_done_lat", 32'(doneCyc - lastEngCyc), 1);
    chk("clr_span", 32'(doneCyc - ackCyc), 32'(RAM) + 1);

    // column bars
    barCase("bar5", 5, 100, 8'h0F, 8'h00);
    barCase("barsat", 639, 511, 8'h77, 8'h11);
    barCase("barzero", 0, 0, 8'h77, 8'h11);

    // off-screen column: acknowledged, nothing written
    arm(1, 700, 10, 8'h00, 8'h22, 8'h33, 19'h7FFFF);
    reqBar(700, 10, 8'h22, 8'h33);
    waitDone("barx", 10);
    chk("barx_wr", 32'(engWr), 0);
    chk("barx_ack", 32'(ackCnt), 1);
    chk("barx_done_lat", 32'(doneCyc - ackCyc), 1);

    // register-space host write during a bar
    arm(1, 3, 7, 8'h00, 8'h44, 8'h55, 19'h4B003);
    reqBar(3, 7, 8'h44, 8'h55);
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.iHOST_WR = 1'b1; bus.iHOST_ADDR = 19'h4B003; bus.iHOST_DATA = 8'hA5;
      #2;
      waits += int'(bus.oHOST_WAIT);
    end
    @(negedge clk);
    bus.iHOST_WR = 1'b0;
    waitDone("regw", 700);
    chk("regw_wait", 32'(waits), 0);
    chk("regw_fwd", 32'(hostWr), 0);
    chk("regw_wr", 32'(engWr), 480);
    chk("regw_bad", 32'(engBad), 0);
    chk("regw_span", 32'(doneCyc - ackCyc), 481);

    // clear with the host hammering pixel 0x10
    arm(0, 0, 0, 8'h3C, 8'h00, 8'h00, 19'h10);
    reqClr(8'h3C);
    repeat (5) @(negedge clk);
    waits = 0; reps = 0; pw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i != 0) @(negedge clk);
      bus.iHOST_WR = 1'b1; bus.iHOST_ADDR = 19'h10; bus.iHOST_DATA = 8'hA5;
      #2;
      w = bus.oHOST_WAIT;
      waits += int'(w);
      if (i != 0 && w == pw) reps++;
      pw = w;
    end
    @(negedge clk);
    bus.iHOST_WR = 1'b0;
    waitDone("host", 32'(RAM) + 300);
`ifdef VGA_FB_SCHED_FAIR_EN
    chk("host_waits", 32'(waits), 50);
    chk("host_alt", 32'(reps), 0);
    chk("host_fwd", 32'(hostWr), 50);
`else
    chk("host_waits", 32'(waits), 0);
    chk("host_fwd", 32'(hostWr), 100);
`endif
    chk("host_clr_wr", 32'(engWr), 32'(RAM));
    chk("host_clr_bad", 32'(engBad), 0);
    chk("host_span", 32'(doneCyc - ackCyc), 32'(RAM) + 32'(hostWr) + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/vga_fb_write_sched.md
# vga_fb_write_sched

Write-port scheduler for the 8-bit indexed-colour VGA frame buffer (640x480, one palette index per pixel). Shares the frame buffer's single write port between Avalon host pixel writes and two hardware engines: a full-screen clear and a spectrum column-bar painter. Sits between the Avalon slave decode and the dual-clock frame buffer's write side, in the host clock domain; the VGA read side is untouched.

## Interface
- RAM_SIZE, 19'h4B000, pixel count; host addresses at or above it are register space and never forwarded.
- H_RES, 640, pixels per line; row stride for address stepping.
- V_RES, 480, lines per frame; bar length.
- avs_s1_clk_iCLK  in  1  host clock; sole clock.
- avs_s1_reset_n_iRST_N  in  1  asynchronous, active-low reset.
- iHOST_WR  in  1  host pixel write strobe, already qualified by chipselect.
- iHOST_ADDR  in  19  host pixel address.
- iHOST_DATA  in  8  host palette index.
- oHOST_WAIT  out  1  Avalon waitrequest, combinational.
- iCLR_REQ  in  1  level request: fill whole buffer.
- iCLR_COLOR  in  8  clear index.
- iBAR_REQ  in  1  level request: paint one column bar.
- iBAR_X  in  10  column.
- iBAR_H  in  9  bar height in pixels, from bottom.
- iBAR_FG / iBAR_BG  in  8 each  bar / background index.
- oACK  out  1  one-cycle pulse: request accepted, operands latched.
- oBUSY  out  1  engine not IDLE.
- oDONE  out  1  one-cycle pulse: engine finished.
- oFB_WREN  out  1  frame buffer write enable.
- oFB_ADDR  out  19  frame buffer write address.
- oFB_DATA  out  8  frame buffer write data.

## Operation
- States: IDLE, CLEAR, BAR, DONE. Requests sampled only in IDLE; CLR wins over BAR when both high. Accept latches operands, pulses oACK, moves to CLEAR or BAR.
- CLEAR: writes iCLR_COLOR to addresses 0..RAM_SIZE-1, ascending, one per granted cycle.
- BAR: writes rows y=0..V_RES-1 at address y*H_RES+X, stepped by adding H_RES (no multiplier). Row y gets FG when y >= V_RES-H, else BG. H > V_RES saturates to V_RES; H=0 paints all BG.
- iBAR_X >= H_RES: accepted (oACK), zero writes, straight to DONE.
- After last write: DONE for one cycle (oDONE=1), then IDLE.
- Host writes with iHOST_ADDR >= RAM_SIZE: never forwarded, never stalled.
- Arbitration: one frame-buffer write per cycle. Host-versus-engine policy set by Configuration. A stalled engine holds its address/row; no pixel skipped or repeated.
- Reset (any time, including mid-fill): state IDLE, all outputs 0, engine progress discarded.

## Timing
- Reset values: oHOST_WAIT, oACK, oBUSY, oDONE, oFB_WREN = 0; oFB_ADDR, oFB_DATA = 0.
- oFB_* registered: host write granted in cycle N appears on oFB_* in cycle N+1.
- Accept edge N: oACK and oBUSY high in cycle N+1; first engine write on oFB_* in cycle N+2 if not preempted.
- Unstalled CLEAR: RAM_SIZE consecutive write cycles; BAR: V_RES; oDONE the cycle after the last write's oFB_WREN.
- oBUSY low in the cycle oDONE is high; a new request may be accepted in that DONE→IDLE cycle's successor.

## Configuration
- VGA_FB_SCHED_FAIR_EN defined: when engine active and host write valid, grant alternates; if engine had the previous grant, host wins, else engine wins and oHOST_WAIT=1 (host holds strobe). Host never waits while IDLE or in DONE.
- Undefined: fixed host priority; oHOST_WAIT tied 0; engine stalls every cycle the host writes a pixel.

## Structure
- Package vga_fb_pkg: state enum, H_RES/V_RES/RAM_SIZE defaults, pixel index width (8), address width (19).
- One sub-module vga_fb_addr_gen: loadable address/row counter with step (1 or H_RES), terminal count and hold-on-stall.

## Test plan
- Reset mid-CLEAR at address 0x100 -> all outputs 0 immediately; after release no writes until new request.
- CLR_REQ, COLOR=0x3C, no host traffic -> 0x4B000 writes, addresses 0..0x4AFFF ascending, data 0x3C, one oDONE.
- BAR X=5 H=100 FG=0x0F BG=0x00 -> 480 writes, addr 5+640y; y<380 data 0x00, y>=380 data 0x0F.
- BAR H=511 -> all 480 rows FG; BAR X=700 -> oACK, no writes, oDONE two cycles later.
- CLEAR plus host writing every cycle to 0x10: without FAIR_EN engine stalls, oHOST_WAIT=0; with FAIR_EN grants alternate, oHOST_WAIT high every other cycle, no clear address skipped.
- Host write to 0x4B003 during BAR -> not on oFB_*, oHOST_WAIT=0, bar unaffected.
